// File: rtl/nest_int_ctrl.sv
// Nested, priority-ordered interrupt controller: edge-detected requests, maskable,
// with a return stack of {source index, EPC} and registered PC redirect.
module nest_int_ctrl #(
  parameter int          N_SRC     = 8,
  parameter int          STK_DEPTH = 4,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0800,
  parameter int          VEC_SHIFT = 4
) (
  input  logic             in_CLK,
  input  logic             in_RSTn,
  input  logic [N_SRC-1:0] in_req,
  input  logic             in_mask_we,
  input  logic [N_SRC-1:0] in_mask_wdata,
  input  logic             in_IE,
  input  logic             in_take_ok,
  input  logic             in_eret,
  input  logic [31:0]      in_EPC,
  input  logic             in_FDCLR,
  input  logic             in_DECLR,
  output logic             R_FDCLR,
  output logic             R_DECLR,
  output logic             R_EECLR,
  output logic             out_force,
  output logic [31:0]      out_pc,
  output logic [N_SRC-1:0] out_IG,
  output logic [N_SRC-1:0] out_pend,
  output logic [N_SRC-1:0] out_mask,
  output logic [3:0]       out_depth,
  output logic             out_err
);

  // LW must hold N_SRC itself, which encodes "no source in service".
  localparam int LW = $clog2(N_SRC + 1);
  localparam int SW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [N_SRC-1:0] req_q, pend_q, pend_d, mask_q, mask_d;
  logic [N_SRC-1:0] rise, elig, below_lvl, sel_oh, top_oh, ig_q, ig_d;
  logic [3:0]       depth_q, depth_d;
  logic             force_q, force_d, err_q, err_d;
  logic [31:0]      pc_q, pc_d;
  logic [LW-1:0]    level, sel_idx;
  logic [SW-1:0]    push_ptr, top_ptr;
  logic             take, pop;

  logic [LW-1:0]    stk_idx_q [STK_DEPTH];
  logic [31:0]      stk_epc_q [STK_DEPTH];

  assign push_ptr = SW'(depth_q);
  assign top_ptr  = SW'(depth_q - 4'd1);
  assign level    = (depth_q == 4'd0) ? LW'(N_SRC) : stk_idx_q[top_ptr];
  assign rise     = in_req & ~req_q;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign below_lvl[gi] = (LW'(gi) < level);
    assign top_oh[gi]    = (stk_idx_q[top_ptr] == LW'(gi));
  end

  assign elig = pend_q & ~mask_q & below_lvl;

  // Descending scan so the lowest eligible index wins.
  always_comb begin
    sel_idx = '0;
    sel_oh  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel_idx   = LW'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign pop  = in_eret && (depth_q != 4'd0);
  assign take = (|elig) && in_IE && in_take_ok && !in_eret &&
                (depth_q < 4'(STK_DEPTH));

  always_comb begin
    pend_d  = (pend_q & ~({N_SRC{take}} & sel_oh)) | rise;
    mask_d  = in_mask_we ? in_mask_wdata : mask_q;
    depth_d = depth_q;
    force_d = 1'b0;
    pc_d    = '0;
    ig_d    = '0;
    err_d   = err_q;
    if (pop) begin
      depth_d = depth_q - 4'd1;
      force_d = 1'b1;
      pc_d    = stk_epc_q[top_ptr];
      ig_d    = top_oh;
    end else if (in_eret) begin
      err_d = 1'b1;
    end else if (take) begin
      depth_d = depth_q + 4'd1;
      force_d = 1'b1;
      pc_d    = VEC_BASE + (32'(sel_idx) << VEC_SHIFT);
    end
  end

  always_ff @(posedge in_CLK or negedge in_RSTn) begin
    if (!in_RSTn) begin
      req_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      depth_q <= '0;
      force_q <= 1'b0;
      pc_q    <= '0;
      ig_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      req_q   <= in_req;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      depth_q <= depth_d;
      force_q <= force_d;
      pc_q    <= pc_d;
      ig_q    <= ig_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset: depth_q alone decides which entries are live.
  always_ff @(posedge in_CLK) begin
    if (take) begin
      stk_idx_q[push_ptr] <= sel_idx;
      stk_epc_q[push_ptr] <= in_EPC;
    end
  end

  assign R_FDCLR   = !in_RSTn || force_q || in_FDCLR;
  assign R_DECLR   = !in_RSTn || force_q || in_DECLR;
  assign R_EECLR   = !in_RSTn || force_q;
  assign out_force = force_q;
  assign out_pc    = pc_q;
  assign out_IG    = ig_q;
  assign out_pend  = pend_q;
  assign out_mask  = mask_q;
  assign out_depth = depth_q;
  assign out_err   = err_q;

endmodule
